// File: rtl/ft_fifo_rb.sv
// ft_fifo_rb: single-clock circular-buffer FIFO with occupancy level,
// almost-full/almost-empty thresholds, sticky overflow/underflow flags,
// synchronous flush and selectable first-word-fall-through or registered read.
module ft_fifo_rb #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 32,
    parameter int AF_LVL = DEPTH - 4,
    parameter int AE_LVL = 4,
    parameter int FWFT   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         d_in,
    input  logic                     w_en,
    input  logic                     r_en,
    input  logic                     flush,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         d_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic                     udf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] C_DEPTH = LW'(DEPTH);
    localparam logic [LW-1:0] C_AF    = LW'(AF_LVL);
    localparam logic [LW-1:0] C_AE    = LW'(AE_LVL);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_ovf;
    logic             r_udf;

    logic             w_full;
    logic             w_empty;
    logic             w_rd_ok;
    logic             w_wr_ok;
    logic             w_ovf_set;
    logic             w_udf_set;
    logic             w_do_rd;
    logic             w_do_wr;

    // Status flags and transfer acceptance, all from the registered level
    always_comb begin
        w_full    = (r_level == C_DEPTH);
        w_empty   = (r_level == '0);
        w_rd_ok   = r_en & ~w_empty;
        w_wr_ok   = w_en & (~w_full | w_rd_ok);
        w_do_rd   = w_rd_ok & ~flush;
        w_do_wr   = w_wr_ok & ~flush;
        w_ovf_set = w_en & ~w_wr_ok & ~flush;
        w_udf_set = r_en & ~w_rd_ok & ~flush;
    end

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_level >= C_AF);
    assign almost_empty = (r_level <= C_AE);
    assign level        = r_level;
    assign ovf          = r_ovf;
    assign udf          = r_udf;

    // Storage array: written at the write pointer, never shifted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_wr) begin
            r_mem[r_wr_ptr] <= d_in;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
        end
    end

    // Occupancy: simultaneous read and write leave it unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else if (flush) begin
            r_level <= '0;
        end else begin
            case ({w_do_wr, w_do_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky error flags: a new error on the clearing edge wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_ovf_set)    r_ovf <= 1'b1;
            else if (clr_err) r_ovf <= 1'b0;
            if (w_udf_set)    r_udf <= 1'b1;
            else if (clr_err) r_udf <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented immediately whenever the FIFO is non-empty
            assign d_out = r_mem[r_rd_ptr];
        end else begin : g_reg
            logic [WIDTH-1:0] r_dout;

            // Registered read: load the head word on an accepted read, hold otherwise
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout <= '0;
                end else if (w_do_rd) begin
                    r_dout <= r_mem[r_rd_ptr];
                end
            end

            assign d_out = r_dout;
        end
    endgenerate

endmodule

// File: tb/tb_ft_fifo_rb.sv
// Scoreboard bench for ft_fifo_rb: one FWFT and one registered-read instance
// share the same stimulus; a queue-based reference model predicts data and flags.
module tb_ft_fifo_rb;

    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] d_in = '0;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic       flush = 1'b0;
    logic       clr_err = 1'b0;

    logic [7:0] ft_dout, rg_dout;
    logic       ft_full, ft_empty, ft_af, ft_ae, ft_ovf, ft_udf;
    logic       rg_full, rg_empty, rg_af, rg_ae, rg_ovf, rg_udf;
    logic [2:0] ft_level, rg_level;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] exp_ft[$];
    logic [7:0] exp_rg[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic [7:0] m_rg_hold = '0;
    bit         rg_pend = 0;

    always #5 clk = ~clk;

    ft_fifo_rb #(.WIDTH(8), .DEPTH(DEPTH), .AF_LVL(AF), .AE_LVL(AE), .FWFT(1)) u_ft (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .w_en(w_en), .r_en(r_en),
        .flush(flush), .clr_err(clr_err), .d_out(ft_dout), .full(ft_full),
        .empty(ft_empty), .almost_full(ft_af), .almost_empty(ft_ae),
        .level(ft_level), .ovf(ft_ovf), .udf(ft_udf)
    );

    ft_fifo_rb #(.WIDTH(8), .DEPTH(DEPTH), .AF_LVL(AF), .AE_LVL(AE), .FWFT(0)) u_rg (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .w_en(w_en), .r_en(r_en),
        .flush(flush), .clr_err(clr_err), .d_out(rg_dout), .full(rg_full),
        .empty(rg_empty), .almost_full(rg_af), .almost_empty(rg_ae),
        .level(rg_level), .ovf(rg_ovf), .udf(rg_udf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] exp_status();
        int n;
        n = m_q.size();
        return {n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf, m_udf, 3'(n)};
    endfunction

    // One clock of stimulus; entered and left at posedge+1
    task automatic step(input bit w, input bit r, input bit f, input bit c, input logic [7:0] d);
        bit rd_ok, wr_ok;
        w_en = w; r_en = r; flush = f; clr_err = c; d_in = d;
        rd_ok = !f && r && (m_q.size() > 0);
        wr_ok = !f && w && ((m_q.size() < DEPTH) || rd_ok);
        if (rd_ok) begin
            exp_ft.push_back(m_q[0]);
            exp_rg.push_back(m_q[0]);
        end
        @(posedge clk); #1;
        if (f) begin
            m_q.delete();
        end else begin
            if (rd_ok) m_rg_hold = m_q.pop_front();
            if (wr_ok) m_q.push_back(d);
        end
        if (w && !wr_ok && !f)  m_ovf = 1'b1;
        else if (c)             m_ovf = 1'b0;
        if (r && !rd_ok && !f)  m_udf = 1'b1;
        else if (c)             m_udf = 1'b0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 8'h00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        w_en = 0; r_en = 0; flush = 0; clr_err = 0; d_in = '0;
        m_q.delete(); exp_ft.delete(); exp_rg.delete();
        m_ovf = 0; m_udf = 0; m_rg_hold = '0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Monitor: flags every cycle, data whenever a read is presented
    always @(negedge clk) begin
        if (!rst_n) begin
            rg_pend = 0;
        end else begin
            chk("status_ft", {ft_full, ft_empty, ft_af, ft_ae, ft_ovf, ft_udf, ft_level}, exp_status());
            chk("status_rg", {rg_full, rg_empty, rg_af, rg_ae, rg_ovf, rg_udf, rg_level}, exp_status());
            if (rg_pend) begin
                if (exp_rg.size() == 0) chk("rg_sb_underrun", 1, 0);
                else                    chk("rg_data", rg_dout, exp_rg.pop_front());
            end
            chk("rg_hold", rg_dout, m_rg_hold);
            if (r_en && !flush && !ft_empty) begin
                if (exp_ft.size() == 0) chk("ft_sb_underrun", 1, 0);
                else                    chk("ft_data", ft_dout, exp_ft.pop_front());
            end
            rg_pend = r_en && !flush && !rg_empty;
        end
    end

    initial begin
        do_reset();
        chk("rst_empty", ft_empty, 1);
        chk("rst_ae", ft_ae, 1);
        chk("rst_full", ft_full, 0);
        chk("rst_af", ft_af, 0);
        chk("rst_level", ft_level, 0);
        chk("rst_dout_ft", ft_dout, 0);
        chk("rst_dout_rg", rg_dout, 0);
        chk("rst_errs", {ft_ovf, ft_udf, rg_ovf, rg_udf}, 0);

        // Fill and drain
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 8'hA1 + 8'(i));
        chk("fill_full", ft_full, 1);
        chk("fill_level", ft_level, 4);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'h00);
        chk("drain_empty", ft_empty, 1);

        // Wrap at level 2
        step(1, 0, 0, 0, 8'hF0);
        step(1, 0, 0, 0, 8'hF1);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 0, 8'(i));
            chk("wrap_level", rg_level, 2);
        end
        step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);

        // Simultaneous read/write while full
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 8'h10 + 8'(i));
        chk("fullsim_head", ft_dout, 8'h10);
        step(1, 1, 0, 0, 8'h55);
        chk("fullsim_level", ft_level, 4);
        chk("fullsim_ovf", ft_ovf, 0);
        chk("fullsim_rg", rg_dout, 8'h10);

        // Overflow, underflow and clear
        step(1, 0, 0, 0, 8'h66);
        chk("ovf_set", ft_ovf, 1);
        chk("ovf_level", ft_level, 4);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'h00);
        chk("drain_last", rg_dout, 8'h55);
        step(0, 1, 0, 0, 8'h00);
        chk("udf_set", ft_udf, 1);
        step(0, 0, 0, 1, 8'h00);
        chk("clr_both", {ft_ovf, ft_udf}, 0);
        step(0, 1, 0, 1, 8'h00);
        chk("clr_set_wins", rg_udf, 1);
        step(0, 0, 0, 1, 8'h00);

        // Empty with simultaneous read/write
        step(1, 1, 0, 0, 8'h99);
        chk("empty_rw_level", ft_level, 1);
        chk("empty_rw_udf", ft_udf, 1);
        step(0, 1, 0, 1, 8'h00);

        // Flush with a concurrent write
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'hC0 + 8'(i));
        chk("pre_flush_level", ft_level, 3);
        step(1, 0, 1, 0, 8'hEE);
        chk("flush_level", ft_level, 0);
        chk("flush_empty", ft_empty, 1);
        chk("flush_ovf", ft_ovf, 0);
        chk("flush_rg_kept", rg_dout, 8'h99);

        // Registered read latency and hold
        step(1, 0, 0, 0, 8'h3C);
        step(0, 1, 0, 0, 8'h00);
        chk("rg_latency", rg_dout, 8'h3C);
        idle(); idle();
        chk("rg_held", rg_dout, 8'h3C);

        // Reset in the middle of traffic
        step(1, 0, 0, 0, 8'h01);
        step(1, 0, 0, 0, 8'h02);
        do_reset();
        chk("mid_rst_level", rg_level, 0);
        step(1, 0, 0, 0, 8'h77);
        chk("mid_rst_first", ft_dout, 8'h77);
        step(0, 1, 0, 0, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                     $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5,
                     8'($urandom));
            end
        end
        idle(); idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ft_fifo_rb.md
FT_FIFO_RB -- requirements
Module: ft_fifo_rb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 32, number of entries (power of two, >=2).
REQ-003 SHALL have parameter AF_LVL, default DEPTH-4, almost_full threshold (1..DEPTH).
REQ-004 SHALL have parameter AE_LVL, default 4, almost_empty threshold (0..DEPTH-1).
REQ-005 SHALL have parameter FWFT, default 1; 1 = first-word-fall-through, 0 = registered read.
REQ-006 SHALL have port clk  input  1  single clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port d_in  input  WIDTH  write data.
REQ-009 SHALL have port w_en  input  1  write request.
REQ-010 SHALL have port r_en  input  1  read request.
REQ-011 SHALL have port flush  input  1  synchronous empty-the-FIFO command.
REQ-012 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-013 SHALL have port d_out  output  WIDTH  read data.
REQ-014 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-015 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy.
REQ-016 SHALL have ports ovf, udf  output  1 each  sticky overflow and underflow flags.

Function
REQ-017 SHALL store data in a DEPTH-entry circular buffer addressed by wr_ptr/rd_ptr of $clog2(DEPTH) bits; each pointer wraps DEPTH-1 -> 0. No data shifting.
REQ-018 SHALL accept a read (rd_ok) when r_en=1 and empty=0.
REQ-019 SHALL accept a write (wr_ok) when w_en=1 and (full=0 or rd_ok=1); when full, a simultaneous read and write are both accepted.
REQ-020 SHALL, on wr_ok, write d_in to mem[wr_ptr] and advance wr_ptr; on rd_ok, advance rd_ptr.
REQ-021 SHALL update level by +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
REQ-022 SHALL derive full=(level==DEPTH), empty=(level==0), almost_full=(level>=AF_LVL), almost_empty=(level<=AE_LVL) combinationally from registered level; no lag cycle.
REQ-023 SHALL, when FWFT=1, drive d_out=mem[rd_ptr] combinationally; the value is valid whenever empty=0, zero latency.
REQ-024 SHALL, when FWFT=0, load d_out with mem[rd_ptr] on the rising edge where rd_ok=1 (one-cycle latency) and hold it otherwise.
REQ-025 SHALL set ovf on any edge where w_en=1 and wr_ok=0; SHALL set udf on any edge where r_en=1 and rd_ok=0.
REQ-026 SHALL clear ovf and udf on an edge with clr_err=1 unless a new error occurs on the same edge (set wins).
REQ-027 SHALL, on flush=1, zero wr_ptr, rd_ptr and level, ignore w_en/r_en that cycle, raise no ovf/udf, leave memory and registered d_out unchanged; flush has priority over all other operations.
REQ-028 SHALL, with empty and w_en=r_en=1, accept the write, reject the read and set udf.

Reset
REQ-029 SHALL, on rst_n=0, asynchronously clear wr_ptr, rd_ptr, level, ovf, udf, all memory entries and registered d_out to 0.
REQ-030 SHALL hold outputs after reset at empty=1, almost_empty=1, full=0, almost_full=0, level=0, d_out=0, ovf=0, udf=0.
REQ-031 SHALL, on rst_n asserted mid-operation, discard all contents; the first write after release is the first word read.

Verification
REQ-032 SHALL verify fill/drain: DEPTH=4, write 0xA1..0xA4 -> full=1, level=4; read 4 -> data A1,A2,A3,A4 in order, empty=1.
REQ-033 SHALL verify wrap: DEPTH=4, 10 write/read pairs of 0x00..0x09 at level 2 -> in-order output, level stays 2, pointers wrap cleanly.
REQ-034 SHALL verify full-simultaneous: DEPTH=4 full, w_en=r_en=1 with d_in=0x55 -> oldest word read, 0x55 stored, level=4, ovf=0.
REQ-035 SHALL verify errors: write when full -> ovf=1, level unchanged; read when empty -> udf=1; clr_err -> both 0.
REQ-036 SHALL verify flush: level=3, flush=1 with w_en=1 -> next cycle level=0, empty=1, ovf=0.
REQ-037 SHALL verify FWFT=0: write 0x3C, read -> d_out=0x3C one cycle after the read edge, held thereafter.
